uart_tx_arbiter: RTL

//  Shares one UART transmitter between NUM_REQ byte-stream requesters (console, debug, status).
//  - Round-robin arbitration with a packet lock: a grant is held until the requester's last byte,
//    a MAX_BURST cap, or a lock timeout.
//  - Drives the transmitter's start/data handshake and watches its busy flag.
//  - Sits between requester valid/ready streams and the UART TX serializer, in the clk domain.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester streams plus UART TX handshake shared by the arbiter and its neighbours.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_start;
    logic                         tx_busy;
    logic [GW-1:0]                grant_id;
    logic                         grant_active;
    logic                         lock_abort;
    logic                         tx_err;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, grant_active, lock_abort, tx_err
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, grant_active, lock_abort, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART TX; valid in IDLE -> ready +1 -> tx_start +2.
// Backpressure: only the granted requester sees ready, and only while the transmitter is idle.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int MAX_BURST     = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int START_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        rr_ptr, grant_q, winner;
    logic                 any_req;
    logic                 active_q, start_q, abort_q, err_q, last_q;
    logic [DATA_BITS-1:0] data_q;
    logic [BW-1:0]        burst_cnt;
    logic [IW-1:0]        idle_cnt;
    logic [SW-1:0]        wait_cnt;
    logic                 g_valid, g_last;
    logic [DATA_BITS-1:0] g_data;
    logic                 grant_now, handshake, idle_to, start_to, byte_done, release_now;

    // Two passes give a wrap-around scan starting at rr_ptr.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && bus.req_valid[i] && (GW'(i) >= rr_ptr)) begin
                any_req = 1'b1;
                winner  = GW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && bus.req_valid[i]) begin
                any_req = 1'b1;
                winner  = GW'(i);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign grant_now   = (state == IDLE) && any_req && !bus.tx_busy;
    assign handshake   = (state == ISSUE) && g_valid && !bus.tx_busy;
    assign idle_to     = (state == ISSUE) && !g_valid && (idle_cnt == IW'(LOCK_TIMEOUT - 1));
    assign start_to    = (state == WAIT_BUSY) && !bus.tx_busy && (wait_cnt == SW'(START_TIMEOUT - 1));
    assign byte_done   = ((state == WAIT_DONE) && !bus.tx_busy) || start_to;
    assign release_now = byte_done && (last_q || (burst_cnt == BW'(MAX_BURST)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_now) state_nxt = ISSUE;
            ISSUE:     if (handshake) state_nxt = WAIT_BUSY;
                       else if (idle_to) state_nxt = IDLE;
            WAIT_BUSY: if (bus.tx_busy) state_nxt = WAIT_DONE;
                       else if (start_to) state_nxt = release_now ? IDLE : ISSUE;
            WAIT_DONE: if (byte_done) state_nxt = release_now ? IDLE : ISSUE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (state == ISSUE) && (GW'(i) == grant_q) && !bus.tx_busy;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant_q   <= '0;
            active_q  <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            wait_cnt  <= '0;
        end else begin
            start_q <= handshake;
            abort_q <= idle_to;
            err_q   <= start_to;
            if (grant_now) begin
                grant_q   <= winner;
                active_q  <= 1'b1;
                burst_cnt <= '0;
                idle_cnt  <= '0;
            end
            if (handshake) begin
                data_q    <= g_data;
                last_q    <= g_last;
                burst_cnt <= burst_cnt + BW'(1);
                idle_cnt  <= '0;
                wait_cnt  <= '0;
            end else if ((state == ISSUE) && !g_valid) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
            if ((state == WAIT_BUSY) && !bus.tx_busy) wait_cnt <= wait_cnt + SW'(1);
            // grant_id is left at the released requester so software can see who went last.
            if (release_now || idle_to) begin
                active_q <= 1'b0;
                rr_ptr   <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            end
        end
    end

    assign bus.tx_data      = data_q;
    assign bus.tx_start     = start_q;
    assign bus.grant_id     = grant_q;
    assign bus.grant_active = active_q;
    assign bus.lock_abort   = abort_q;
    assign bus.tx_err       = err_q;
endmodule
